// File: rtl/multicycle_ctrl.sv
// Multi-cycle MIPS control unit: latches the fetched instruction into IR, walks a Moore FSM
// through IF/ID/EX/MEM/WB and counts retired instructions.
module multicycle_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    output logic        ir_wr,
    output logic        pc_wr,
    output logic        jr,
    output logic        jump,
    output logic        npc_sel,
    output logic        reg_wr,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        alu_src,
    output logic [2:0]  alu_op,
    output logic        ext_op,
    output logic        mem_wr,
    output logic [2:0]  state,
    output logic [31:0] retired
);

    typedef enum logic [2:0] {
        StIf  = 3'd0,
        StId  = 3'd1,
        StEx  = 3'd2,
        StMem = 3'd3,
        StWb  = 3'd4
    } state_e;

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpOri   = 6'h0d;
    localparam logic [5:0] OpLui   = 6'h0f;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2b;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpJal   = 6'h03;
    localparam logic [5:0] FnAddu  = 6'h21;
    localparam logic [5:0] FnSubu  = 6'h23;
    localparam logic [5:0] FnJr    = 6'h08;

    state_e      state_q, state_d;
    logic [31:0] ir_q, ir_d;
    logic [31:0] retired_q, retired_d;

    logic [5:0] op, funct;
    logic is_addu, is_subu, is_jr, is_ori, is_lui, is_lw, is_sw, is_beq, is_j, is_jal, is_nop;

    // Only opcode and funct drive decode; the operand fields belong to the datapath.
    logic unused_ir;
    assign unused_ir = ^ir_q[25:6];

    assign op    = ir_q[31:26];
    assign funct = ir_q[5:0];

    always_comb begin
        is_addu = (op == OpRtype) && (funct == FnAddu);
        is_subu = (op == OpRtype) && (funct == FnSubu);
        is_jr   = (op == OpRtype) && (funct == FnJr);
        is_ori  = (op == OpOri);
        is_lui  = (op == OpLui);
        is_lw   = (op == OpLw);
        is_sw   = (op == OpSw);
        is_beq  = (op == OpBeq);
        is_j    = (op == OpJ);
        is_jal  = (op == OpJal);
        is_nop  = !(is_addu || is_subu || is_jr || is_ori || is_lui || is_lw || is_sw ||
                    is_beq || is_j || is_jal);
    end

    // ALU/extender setup for the current IR, applied from EX onward so operands stay stable.
    logic [2:0] alu_op_ir;
    logic       alu_src_ir;
    logic       ext_op_ir;

    always_comb begin
        alu_op_ir  = 3'd0;
        alu_src_ir = 1'b0;
        ext_op_ir  = 1'b0;
        if (is_subu || is_beq) begin
            alu_op_ir = 3'd1;
        end else if (is_ori) begin
            alu_op_ir  = 3'd2;
            alu_src_ir = 1'b1;
        end else if (is_lui) begin
            alu_op_ir  = 3'd3;
            alu_src_ir = 1'b1;
        end else if (is_lw || is_sw) begin
            alu_src_ir = 1'b1;
            ext_op_ir  = 1'b1;
        end
    end

    always_comb begin
        state_d    = StIf;
        ir_wr      = 1'b0;
        pc_wr      = 1'b0;
        jr         = 1'b0;
        jump       = 1'b0;
        npc_sel    = 1'b0;
        reg_wr     = 1'b0;
        reg_dst    = 2'd0;
        mem_to_reg = 2'd0;
        alu_src    = 1'b0;
        alu_op     = 3'd0;
        ext_op     = 1'b0;
        mem_wr     = 1'b0;

        case (state_q)
            StIf: begin
                ir_wr   = 1'b1;
                state_d = StId;
            end
            StId: begin
                if (is_j) begin
                    jump  = 1'b1;
                    pc_wr = 1'b1;
                end else if (is_jr) begin
                    jr    = 1'b1;
                    pc_wr = 1'b1;
                end else if (is_nop) begin
                    pc_wr = 1'b1;
                end else if (is_jal) begin
                    state_d = StWb;
                end else begin
                    state_d = StEx;
                end
            end
            StEx: begin
                alu_op  = alu_op_ir;
                alu_src = alu_src_ir;
                ext_op  = ext_op_ir;
                if (is_beq) begin
                    npc_sel = 1'b1;
                    pc_wr   = 1'b1;
                end else if (is_lw || is_sw) begin
                    state_d = StMem;
                end else begin
                    state_d = StWb;
                end
            end
            StMem: begin
                alu_op  = alu_op_ir;
                alu_src = alu_src_ir;
                ext_op  = ext_op_ir;
                if (is_sw) begin
                    mem_wr = 1'b1;
                    pc_wr  = 1'b1;
                end else if (is_lw) begin
                    state_d = StWb;
                end
            end
            StWb: begin
                alu_op  = alu_op_ir;
                alu_src = alu_src_ir;
                ext_op  = ext_op_ir;
                reg_wr  = 1'b1;
                pc_wr   = 1'b1;
                if (is_addu || is_subu) begin
                    reg_dst = 2'd1;
                end else if (is_lw) begin
                    mem_to_reg = 2'd1;
                end else if (is_jal) begin
                    // PC has not advanced yet, so PC+4 is still the jal's return address.
                    reg_dst    = 2'd2;
                    mem_to_reg = 2'd2;
                    jump       = 1'b1;
                end
            end
            default: state_d = StIf;
        endcase

        // Reset must silence every control, including the IF-state ir_wr.
        if (!reset) begin
            ir_wr      = 1'b0;
            pc_wr      = 1'b0;
            jr         = 1'b0;
            jump       = 1'b0;
            npc_sel    = 1'b0;
            reg_wr     = 1'b0;
            reg_dst    = 2'd0;
            mem_to_reg = 2'd0;
            alu_src    = 1'b0;
            alu_op     = 3'd0;
            ext_op     = 1'b0;
            mem_wr     = 1'b0;
        end
    end

    always_comb begin
        ir_d      = ir_wr ? instr : ir_q;
        retired_d = pc_wr ? retired_q + 32'd1 : retired_q;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= StIf;
            ir_q      <= 32'd0;
            retired_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            retired_q <= retired_d;
        end
    end

    assign state   = state_q;
    assign retired = retired_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed bench for multicycle_ctrl: per-instruction state/control sequences, reset and wrap.
module tb_multicycle_ctrl;

    logic        clk;
    logic        reset;
    logic [31:0] instr;
    logic        ir_wr, pc_wr, jr, jump, npc_sel, reg_wr, alu_src, ext_op, mem_wr;
    logic [1:0]  reg_dst, mem_to_reg;
    logic [2:0]  alu_op, state;
    logic [31:0] retired;

    int vectors;
    int miscompares;
    logic [31:0] exp_ret;

    multicycle_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .instr      (instr),
        .ir_wr      (ir_wr),
        .pc_wr      (pc_wr),
        .jr         (jr),
        .jump       (jump),
        .npc_sel    (npc_sel),
        .reg_wr     (reg_wr),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .alu_src    (alu_src),
        .alu_op     (alu_op),
        .ext_op     (ext_op),
        .mem_wr     (mem_wr),
        .state      (state),
        .retired    (retired)
    );

    // {ir_wr,pc_wr,jr,jump,npc_sel,reg_wr,reg_dst[1:0],mem_to_reg[1:0],alu_src,alu_op[2:0],
    //  ext_op,mem_wr}
    logic [15:0] ctl;
    assign ctl = {ir_wr, pc_wr, jr, jump, npc_sel, reg_wr, reg_dst, mem_to_reg, alu_src, alu_op,
                  ext_op, mem_wr};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, bench did not finish");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b0;
        instr = 32'h0;
        #3;
        vectors++;
        if (state !== 3'd0) begin
            miscompares++;
            $display("FAIL reset_state: got %0d want 0", state);
        end
        vectors++;
        if (ctl !== 16'h0000) begin
            miscompares++;
            $display("FAIL reset_ctl: got %h want 0000", ctl);
        end
        vectors++;
        if (retired !== 32'd0) begin
            miscompares++;
            $display("FAIL reset_retired: got %h want 0", retired);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if (ctl !== 16'h8000) begin
            miscompares++;
            $display("FAIL reset_release_ctl: got %h want 8000", ctl);
        end
    endtask

    task automatic test_reset_mid();
        logic [2:0]  es [4];
        logic [15:0] ec [4];
        es = '{3'd0, 3'd1, 3'd2, 3'd3};
        ec = '{16'h8000, 16'h0000, 16'h0022, 16'h0022};
        instr = 32'h8c820004;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (state !== es[i]) begin
                miscompares++;
                $display("FAIL mid_lw_state[%0d]: got %0d want %0d", i, state, es[i]);
            end
            vectors++;
            if (ctl !== ec[i]) begin
                miscompares++;
                $display("FAIL mid_lw_ctl[%0d]: got %h want %h", i, ctl, ec[i]);
            end
            if (i < 3) @(negedge clk);
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (state !== 3'd0) begin
            miscompares++;
            $display("FAIL mid_reset_state: got %0d want 0", state);
        end
        vectors++;
        if (ctl !== 16'h0000) begin
            miscompares++;
            $display("FAIL mid_reset_ctl: got %h want 0000", ctl);
        end
        vectors++;
        if (retired !== 32'd0) begin
            miscompares++;
            $display("FAIL mid_reset_retired: got %h want 0", retired);
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        vectors++;
        if (ctl !== 16'h8000 || state !== 3'd0) begin
            miscompares++;
            $display("FAIL mid_release: got ctl %h state %0d want 8000 state 0", ctl, state);
        end
        exp_ret = 32'd0;
    endtask

    task automatic test_addu();
        logic [2:0]  es [4];
        logic [15:0] ec [4];
        es = '{3'd0, 3'd1, 3'd2, 3'd4};
        ec = '{16'h8000, 16'h0000, 16'h0000, 16'h4500};
        instr = 32'h00851021;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (state !== es[i]) begin
                miscompares++;
                $display("FAIL addu_state[%0d]: got %0d want %0d", i, state, es[i]);
            end
            vectors++;
            if (ctl !== ec[i]) begin
                miscompares++;
                $display("FAIL addu_ctl[%0d]: got %h want %h", i, ctl, ec[i]);
            end
            @(negedge clk);
        end
        exp_ret++;
        vectors++;
        if (retired !== exp_ret) begin
            miscompares++;
            $display("FAIL addu_retired: got %0d want %0d", retired, exp_ret);
        end
    endtask

    task automatic test_alu_ops();
        logic [31:0] iw [3];
        logic [15:0] ex [3];
        logic [15:0] wb [3];
        iw = '{32'h00851023, 32'h34820004, 32'h3c020001};  // subu, ori, lui
        ex = '{16'h0004, 16'h0028, 16'h002c};
        wb = '{16'h4504, 16'h4428, 16'h442c};
        for (int k = 0; k < 3; k++) begin
            instr = iw[k];
            @(negedge clk);
            @(negedge clk);
            vectors++;
            if (state !== 3'd2 || ctl !== ex[k]) begin
                miscompares++;
                $display("FAIL alu%0d_ex: got state %0d ctl %h want state 2 ctl %h",
                         k, state, ctl, ex[k]);
            end
            @(negedge clk);
            vectors++;
            if (state !== 3'd4 || ctl !== wb[k]) begin
                miscompares++;
                $display("FAIL alu%0d_wb: got state %0d ctl %h want state 4 ctl %h",
                         k, state, ctl, wb[k]);
            end
            @(negedge clk);
            exp_ret++;
            vectors++;
            if (retired !== exp_ret || state !== 3'd0) begin
                miscompares++;
                $display("FAIL alu%0d_retire: got %0d state %0d want %0d state 0",
                         k, retired, state, exp_ret);
            end
        end
    endtask

    task automatic test_load_store();
        logic [2:0]  es [5];
        logic [15:0] ec [5];
        es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4};
        ec = '{16'h8000, 16'h0000, 16'h0022, 16'h0022, 16'h4462};
        instr = 32'h8c820004;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (state !== es[i] || ctl !== ec[i]) begin
                miscompares++;
                $display("FAIL lw[%0d]: got state %0d ctl %h want state %0d ctl %h",
                         i, state, ctl, es[i], ec[i]);
            end
            @(negedge clk);
        end
        exp_ret++;
        es = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd0};
        ec = '{16'h8000, 16'h0000, 16'h0022, 16'h4023, 16'h8000};
        instr = 32'hac820004;
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (state !== es[i] || ctl !== ec[i]) begin
                miscompares++;
                $display("FAIL sw[%0d]: got state %0d ctl %h want state %0d ctl %h",
                         i, state, ctl, es[i], ec[i]);
            end
            if (i < 4) @(negedge clk);
        end
        exp_ret++;
        vectors++;
        if (retired !== exp_ret) begin
            miscompares++;
            $display("FAIL ls_retired: got %0d want %0d", retired, exp_ret);
        end
    endtask

    task automatic test_beq();
        instr = 32'h10850003;
        @(negedge clk);
        instr = 32'hffffffff;
        #1;
        vectors++;
        if (state !== 3'd1 || ctl !== 16'h0000) begin
            miscompares++;
            $display("FAIL beq_id: got state %0d ctl %h want state 1 ctl 0000", state, ctl);
        end
        @(negedge clk);
        instr = 32'h10850003;
        #1;
        instr = 32'hffffffff;
        #1;
        vectors++;
        if (state !== 3'd2 || ctl !== 16'h4804) begin
            miscompares++;
            $display("FAIL beq_ex: got state %0d ctl %h want state 2 ctl 4804", state, ctl);
        end
        @(negedge clk);
        exp_ret++;
        vectors++;
        if (state !== 3'd0 || retired !== exp_ret) begin
            miscompares++;
            $display("FAIL beq_done: got state %0d retired %0d want 0 / %0d",
                     state, retired, exp_ret);
        end
    endtask

    task automatic test_jumps();
        logic [31:0] iw [3];
        logic [15:0] ec [3];
        logic [2:0]  ls [3];
        int          nc [3];
        iw = '{32'h0c000c05, 32'h03e00008, 32'h08000c00};  // jal, jr, j
        ec = '{16'h5680, 16'h6000, 16'h5000};
        ls = '{3'd4, 3'd1, 3'd1};
        nc = '{3, 2, 2};
        for (int k = 0; k < 3; k++) begin
            instr = iw[k];
            for (int c = 1; c < nc[k]; c++) begin
                @(negedge clk);
                if (c < nc[k] - 1) begin
                    vectors++;
                    if (state !== 3'd1 || ctl !== 16'h0000) begin
                        miscompares++;
                        $display("FAIL jmp%0d_id: got state %0d ctl %h want state 1 ctl 0000",
                                 k, state, ctl);
                    end
                end
            end
            vectors++;
            if (state !== ls[k] || ctl !== ec[k]) begin
                miscompares++;
                $display("FAIL jmp%0d_last: got state %0d ctl %h want state %0d ctl %h",
                         k, state, ctl, ls[k], ec[k]);
            end
            @(negedge clk);
            exp_ret++;
            vectors++;
            if (state !== 3'd0 || retired !== exp_ret) begin
                miscompares++;
                $display("FAIL jmp%0d_done: got state %0d retired %0d want 0 / %0d",
                         k, state, retired, exp_ret);
            end
        end
    endtask

    task automatic test_undef_wrap();
        instr = 32'hfc000000;
        @(negedge clk);
        vectors++;
        if (state !== 3'd1 || ctl !== 16'h4000) begin
            miscompares++;
            $display("FAIL undef_id: got state %0d ctl %h want state 1 ctl 4000", state, ctl);
        end
        @(negedge clk);
        exp_ret++;
        vectors++;
        if (state !== 3'd0 || retired !== exp_ret) begin
            miscompares++;
            $display("FAIL undef_done: got state %0d retired %0d want 0 / %0d",
                     state, retired, exp_ret);
        end
        instr = 32'h00000000;
        force dut.retired_q = 32'hffffffff;
        @(negedge clk);
        release dut.retired_q;
        #1;
        vectors++;
        if (state !== 3'd1 || ctl !== 16'h4000 || retired !== 32'hffffffff) begin
            miscompares++;
            $display("FAIL nop_id: got state %0d ctl %h retired %h want 1 4000 ffffffff",
                     state, ctl, retired);
        end
        @(negedge clk);
        vectors++;
        if (retired !== 32'd0) begin
            miscompares++;
            $display("FAIL wrap: got %h want 00000000", retired);
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        exp_ret     = 32'd0;
        test_reset();
        test_reset_mid();
        test_addu();
        test_alu_ops();
        test_load_store();
        test_beq();
        test_jumps();
        test_undef_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
